// File: rtl/array_loader_16x8_pkg.sv
// rtl/array_loader_16x8_pkg.sv - shared sizes and one-hot loader states
package array_loader_16x8_pkg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // Prefixed LD_ so they never collide with the finder's own state names.
  typedef enum logic [4:0] {
    LD_INI  = 5'b00001,
    LD_LOAD = 5'b00010,
    LD_STRT = 5'b00100,
    LD_WAIT = 5'b01000,
    LD_DONE = 5'b10000
  } ld_state_e;

endpackage

// File: rtl/array_mem_16x8.sv
// rtl/array_mem_16x8.sv - register array, synchronous write, asynchronous read
module array_mem_16x8
  import array_loader_16x8_pkg::*;
(
  input  logic             Clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Contents are deliberately not reset; they persist across loader resets.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/array_loader_16x8.sv
// rtl/array_loader_16x8.sv - fills the 16x8 array, starts the finder, waits for done
module array_loader_16x8
  import array_loader_16x8_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic [WIDTH-1:0] Din,
  input  logic             DinValid,
  output logic             DinReady,
  input  logic [AW-1:0]    RdAddr,
  output logic [WIDTH-1:0] RdData,
  output logic             StartOut,
  input  logic             FinderDone,
  output logic [AW:0]      Count,
  output logic             Qi,
  output logic             Ql,
  output logic             Qs,
  output logic             Qw,
  output logic             Qd
);

  ld_state_e     state_q, state_d;
  logic [AW-1:0] j_q, j_d;
  logic          xfer;

  assign xfer = (state_q == LD_LOAD) && DinValid;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    case (state_q)
      LD_INI: begin
        j_d = '0;
        if (Go) state_d = LD_LOAD;
      end
      LD_LOAD: begin
        if (DinValid) begin
          j_d = j_q + 1'b1;
          if (j_q == AW'(DEPTH - 1)) state_d = LD_STRT;
        end
      end
      LD_STRT: state_d = LD_WAIT;
      LD_WAIT: if (FinderDone) state_d = LD_DONE;
      LD_DONE: state_d = LD_INI;
      default: begin
        state_d = LD_INI;
        j_d     = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= LD_INI;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
    end
  end

  // J has wrapped to 0 once the array is full, so the full count is decoded from state.
  always_comb begin
    Count = '0;
    case (state_q)
      LD_LOAD:                   Count = {1'b0, j_q};
      LD_STRT, LD_WAIT, LD_DONE: Count = (AW + 1)'(DEPTH);
      default:                   Count = '0;
    endcase
  end

  assign {Qd, Qw, Qs, Ql, Qi} = state_q;
  assign DinReady = Ql;
  assign StartOut = Qs;

  array_mem_16x8 u_mem (
    .Clk     (Clk),
    .wr_en   (xfer),
    .wr_addr (j_q),
    .wr_data (Din),
    .rd_addr (RdAddr),
    .rd_data (RdData)
  );

endmodule
